bira_repair_sequencer: RTL and testbench

- Controller that sequences the BIRA datapath.
- During test, collects BIST fault reports into a pivot table and raises early termination on spare overflow.
- After test_end, sweeps candidate spare-assignment vectors (DSSS/RLSS) into the validity checker one per cycle and stops at the first valid candidate.
- Then streams per-pivot repair solution words to the top level.

---
 rtl/bira_repair_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_bira_repair_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bira_repair_sequencer.sv
// rtl/bira_repair_sequencer.sv - BIRA sequencer: pivot collection, spare-assignment sweep, repair word stream.
// Optional fault_count output is enabled by defining BIRA_FAULT_COUNT_EN.
module bira_repair_sequencer #(
  parameter int NUM_PIVOT = 8,
  parameter int RLSS_W    = 4,
  parameter int ADDR_W    = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [1:0]                         spare_struct,
  input  logic                               test_end,
  input  logic                               fault_detect,
  input  logic [ADDR_W-1:0]                  row_add_in,
  input  logic [ADDR_W-1:0]                  col_add_in,
  input  logic [1:0]                         bank_in,
  output logic [NUM_PIVOT-1:0]               DSSS,
  output logic [RLSS_W-1:0]                  RLSS,
  input  logic                               signal_valid,
  output logic                               early_term,
  output logic                               busy,
  output logic                               repair,
  output logic                               sol_valid,
  output logic [$clog2(NUM_PIVOT)+ADDR_W+2:0] solution,
  output logic                               done
`ifdef BIRA_FAULT_COUNT_EN
  ,
  output logic [15:0]                        fault_count
`endif
);

  localparam int IDXW = $clog2(NUM_PIVOT);
  localparam int PCW  = $clog2(NUM_PIVOT + 1);
  localparam int CW   = NUM_PIVOT + RLSS_W;
  localparam int SW   = IDXW + ADDR_W + 3;

  typedef enum logic [2:0] {IDLE, COLLECT, ANALYZE, EMIT, DONE} state_t;

  state_t                state_q;
  logic [PCW-1:0]        pivot_cnt_q;
  logic [1:0]            tbl_bank_q [NUM_PIVOT];
  logic [ADDR_W-1:0]     tbl_row_q  [NUM_PIVOT];
  logic [ADDR_W-1:0]     tbl_col_q  [NUM_PIVOT];
  logic [CW-1:0]         cand_q;
  logic                  wrap_q;
  logic                  pres_q;
  logic [NUM_PIVOT-1:0]  sel_q;
  logic [PCW-1:0]        emit_idx_q;
  logic [1:0]            spare_q;
  logic [NUM_PIVOT-1:0]  dsss_q;
  logic [RLSS_W-1:0]     rlss_q;
  logic                  early_term_q, busy_q, repair_q, sol_valid_q, done_q;
  logic [SW-1:0]         solution_q;

  logic [NUM_PIVOT-1:0]  pivot_mask;
  logic                  table_hit;
  logic                  table_full;
  logic                  cand_skip;
  logic                  spare_struct_unused;

  // Spare structure is latched for the downstream datapath; the sequencing itself does not depend on it.
  assign spare_struct_unused = ^spare_q;

  always_comb begin
    pivot_mask = '0;
    table_hit  = 1'b0;
    for (int i = 0; i < NUM_PIVOT; i++) begin
      pivot_mask[i] = (PCW'(i) < pivot_cnt_q);
      if (pivot_mask[i] && (bank_in == tbl_bank_q[i]) &&
          ((row_add_in == tbl_row_q[i]) || (col_add_in == tbl_col_q[i])))
        table_hit = 1'b1;
    end
  end

  assign table_full = (pivot_cnt_q == PCW'(NUM_PIVOT));
  assign cand_skip  = |(cand_q[NUM_PIVOT-1:0] & ~pivot_mask);

  function automatic logic [SW-1:0] mk_word(input logic [IDXW-1:0] idx, input logic use_col);
    return {idx, use_col, tbl_bank_q[idx], use_col ? tbl_col_q[idx] : tbl_row_q[idx]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pivot_cnt_q  <= '0;
      for (int i = 0; i < NUM_PIVOT; i++) begin
        tbl_bank_q[i] <= '0;
        tbl_row_q[i]  <= '0;
        tbl_col_q[i]  <= '0;
      end
      cand_q       <= '0;
      wrap_q       <= 1'b0;
      pres_q       <= 1'b0;
      sel_q        <= '0;
      emit_idx_q   <= '0;
      spare_q      <= '0;
      dsss_q       <= '0;
      rlss_q       <= '0;
      early_term_q <= 1'b0;
      busy_q       <= 1'b0;
      repair_q     <= 1'b0;
      sol_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      solution_q   <= '0;
    end else begin
      sol_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fault_detect) begin
            spare_q       <= spare_struct;
            tbl_bank_q[0] <= bank_in;
            tbl_row_q[0]  <= row_add_in;
            tbl_col_q[0]  <= col_add_in;
            pivot_cnt_q   <= PCW'(1);
          end
          if (test_end) begin
            state_q <= ANALYZE;
            busy_q  <= 1'b1;
          end else if (fault_detect) begin
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (fault_detect && !table_hit && table_full) begin
            early_term_q <= 1'b1;
            done_q       <= 1'b1;
            state_q      <= DONE;
          end else begin
            if (fault_detect && !table_hit) begin
              tbl_bank_q[pivot_cnt_q[IDXW-1:0]] <= bank_in;
              tbl_row_q[pivot_cnt_q[IDXW-1:0]]  <= row_add_in;
              tbl_col_q[pivot_cnt_q[IDXW-1:0]]  <= col_add_in;
              pivot_cnt_q <= pivot_cnt_q + PCW'(1);
            end
            if (test_end) begin
              state_q <= ANALYZE;
              busy_q  <= 1'b1;
            end
          end
        end
        ANALYZE: begin
          if (pivot_cnt_q == '0) begin
            repair_q <= 1'b1;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end else if (pres_q && signal_valid) begin
            // The verdict refers to the candidate currently on DSSS/RLSS; word 0 goes out at once.
            sel_q       <= dsss_q;
            repair_q    <= 1'b1;
            pres_q      <= 1'b0;
            sol_valid_q <= 1'b1;
            solution_q  <= mk_word('0, dsss_q[0]);
            emit_idx_q  <= PCW'(1);
            state_q     <= EMIT;
          end else if (wrap_q) begin
            pres_q  <= 1'b0;
            repair_q <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            if (!cand_skip) begin
              dsss_q <= cand_q[NUM_PIVOT-1:0];
              rlss_q <= cand_q[CW-1:NUM_PIVOT];
            end
            pres_q <= !cand_skip;
            cand_q <= cand_q + CW'(1);
            wrap_q <= &cand_q;
          end
        end
        EMIT: begin
          if (emit_idx_q == pivot_cnt_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            sol_valid_q <= 1'b1;
            solution_q  <= mk_word(emit_idx_q[IDXW-1:0], sel_q[emit_idx_q[IDXW-1:0]]);
            emit_idx_q  <= emit_idx_q + PCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BIRA_FAULT_COUNT_EN
  logic [15:0] fault_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fault_cnt_q <= '0;
    else if (fault_detect && ((state_q == IDLE) || (state_q == COLLECT)) && (fault_cnt_q != 16'hFFFF))
      fault_cnt_q <= fault_cnt_q + 16'd1;
  end

  assign fault_count = fault_cnt_q;
`endif

  assign DSSS       = dsss_q;
  assign RLSS       = rlss_q;
  assign early_term = early_term_q;
  assign busy       = busy_q;
  assign repair     = repair_q;
  assign sol_valid  = sol_valid_q;
  assign solution   = solution_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bira_repair_sequencer.sv
// tb/tb_bira_repair_sequencer.sv - directed, table-driven bench for bira_repair_sequencer.
module tb_bira_repair_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  spare_struct = 2'd1;
  logic        test_end = 1'b0;
  logic        fault_detect = 1'b0;
  logic [9:0]  row_add_in = '0;
  logic [9:0]  col_add_in = '0;
  logic [1:0]  bank_in = '0;
  logic [7:0]  DSSS;
  logic [3:0]  RLSS;
  logic        signal_valid;
  logic        early_term, busy, repair, sol_valid, done;
  logic [15:0] solution;
`ifdef BIRA_FAULT_COUNT_EN
  logic [15:0] fault_count;
`endif

  logic        chk_en = 1'b0;
  logic [7:0]  want_dsss = '0;
  logic [3:0]  want_rlss = '0;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] words[$];
  logic [15:0] exp_words[$];

  typedef struct {
    logic [1:0] bank;
    logic [9:0] row;
    logic [9:0] col;
    logic       pivot;
  } fvec_t;

  fvec_t vecs[7];

  bira_repair_sequencer dut (
    .clk(clk), .rst(rst), .spare_struct(spare_struct), .test_end(test_end),
    .fault_detect(fault_detect), .row_add_in(row_add_in), .col_add_in(col_add_in),
    .bank_in(bank_in), .DSSS(DSSS), .RLSS(RLSS), .signal_valid(signal_valid),
    .early_term(early_term), .busy(busy), .repair(repair), .sol_valid(sol_valid),
    .solution(solution), .done(done)
`ifdef BIRA_FAULT_COUNT_EN
    , .fault_count(fault_count)
`endif
  );

  always #5 clk = ~clk;

  // External validity checker: accepts exactly one DSSS/RLSS pair.
  assign signal_valid = chk_en && (DSSS == want_dsss) && (RLSS == want_rlss);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fault_detect = 1'b0;
    test_end = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic fault(input logic [1:0] b, input logic [9:0] r, input logic [9:0] c, input logic te);
    bank_in = b;
    row_add_in = r;
    col_add_in = c;
    fault_detect = 1'b1;
    test_end = te;
    step();
    fault_detect = 1'b0;
    test_end = 1'b0;
  endtask

  task automatic pulse_te();
    test_end = 1'b1;
    step();
    test_end = 1'b0;
  endtask

  task automatic run_expect(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    words.delete();
    while (!sol_valid && lat < 6000) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    while (sol_valid && words.size() < 16) begin
      words.push_back(solution);
      step();
    end
    check({tag, "_word_count"}, words.size(), exp_words.size());
    for (int i = 0; i < exp_words.size() && i < words.size(); i++)
      check($sformatf("%s_word%0d", tag, i), words[i], exp_words[i]);
    check({tag, "_done"}, done, 1);
    check({tag, "_repair"}, repair, 1);
    check({tag, "_busy_clear"}, busy, 0);
    check({tag, "_early_term"}, early_term, 0);
  endtask

  initial begin
    int   cnt;
    logic seen_sv;
    logic [2:0] k;

    vecs[0] = '{2'd0, 10'd5,   10'd9,   1'b1};
    vecs[1] = '{2'd0, 10'd5,   10'd20,  1'b0};
    vecs[2] = '{2'd1, 10'd5,   10'd9,   1'b1};
    vecs[3] = '{2'd1, 10'd7,   10'd9,   1'b0};
    vecs[4] = '{2'd2, 10'd100, 10'd200, 1'b1};
    vecs[5] = '{2'd2, 10'd100, 10'd200, 1'b0};
    vecs[6] = '{2'd3, 10'd5,   10'd9,   1'b1};

    // Reset values
    #1;
    check("rst_outputs", {DSSS, RLSS, early_term, busy, repair, sol_valid, solution, done}, 0);
    do_reset();
    check("rst_done", done, 0);

    // Pivot classification; checker accepts the all-row candidate
    chk_en = 1'b1;
    want_dsss = 8'h00;
    want_rlss = 4'h0;
    exp_words.delete();
    k = 3'd0;
    for (int i = 0; i < 7; i++) begin
      fault(vecs[i].bank, vecs[i].row, vecs[i].col, 1'b0);
      if (vecs[i].pivot) begin
        exp_words.push_back({k, 1'b0, vecs[i].bank, vecs[i].row});
        k++;
      end
    end
    check("t1_collect_not_busy", busy, 0);
    pulse_te();
    check("t1_analyze_busy", busy, 1);
    check("t1_analyze_dsss", DSSS, 8'h00);
    run_expect("t1", 2);

    // DONE ignores further traffic
    fault(2'd3, 10'd1, 10'd1, 1'b1);
    step();
    check("t1_done_sticky", {done, sol_valid, busy}, 3'b100);

    // Two pivots, fault and test_end together, checker wants DSSS=0x02
    do_reset();
    want_dsss = 8'h02;
    exp_words.delete();
    exp_words.push_back(16'h0005);
    exp_words.push_back(16'h342C);
    fault(2'd0, 10'd5, 10'd9, 1'b0);
    fault(2'd1, 10'd33, 10'd44, 1'b1);
    run_expect("t2", 4);

    // Nine distinct pivots overflow the table
    do_reset();
    for (int i = 0; i < 8; i++)
      fault(2'd0, 10'(i), 10'(100 + i), 1'b0);
    check("t3_no_early_term_at_8", early_term, 0);
    fault(2'd0, 10'd8, 10'd108, 1'b0);
    check("t3_early_term", early_term, 1);
    check("t3_done", done, 1);
    check("t3_repair", repair, 0);
    check("t3_busy", busy, 0);
    seen_sv = 1'b0;
    test_end = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      test_end = 1'b0;
      seen_sv |= sol_valid;
    end
    check("t3_no_words", seen_sv, 0);
    check("t3_held", {early_term, done, busy}, 3'b110);

    // Checker never valid: full 4096-candidate sweep
    do_reset();
    chk_en = 1'b0;
    fault(2'd0, 10'd5, 10'd9, 1'b0);
    fault(2'd1, 10'd6, 10'd10, 1'b0);
    pulse_te();
    check("t4_busy", busy, 1);
    cnt = 0;
    seen_sv = 1'b0;
    while (!done && cnt < 5000) begin
      step();
      cnt++;
      seen_sv |= sol_valid;
    end
    check("t4_sweep_cycles", cnt, 4097);
    check("t4_repair", repair, 0);
    check("t4_no_words", seen_sv, 0);
    check("t4_busy_clear", busy, 0);

    // test_end with no faults
    do_reset();
    chk_en = 1'b1;
    pulse_te();
    check("t5_busy", busy, 1);
    step();
    check("t5_done_repair", {done, repair, sol_valid, busy}, 4'b1100);

    // Async reset mid-EMIT, then a fresh sequence
    do_reset();
    want_dsss = 8'h00;
    fault(2'd0, 10'd1, 10'd2, 1'b0);
    fault(2'd1, 10'd3, 10'd4, 1'b0);
    fault(2'd2, 10'd5, 10'd6, 1'b0);
    pulse_te();
    cnt = 0;
    while (!sol_valid && cnt < 20) begin
      step();
      cnt++;
    end
    check("t6_first_word", solution, 16'h0001);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_clear", {DSSS, RLSS, early_term, busy, repair, sol_valid, solution, done}, 0);
    step();
    rst = 1'b0;
    want_dsss = 8'h03;
    exp_words.delete();
    exp_words.push_back(16'h1402);
    exp_words.push_back(16'h3802);
    fault(2'd1, 10'd1, 10'd2, 1'b0);
    fault(2'd1, 10'd1, 10'd3, 1'b0);
    fault(2'd2, 10'd8, 10'd2, 1'b1);
    run_expect("t6", 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
